// File: rtl/sys_cntrl_v2.sv
// rtl/sys_cntrl_v2.sv - framed command decoder driving RF/ALU handshakes and TX serialisation
module sys_cntrl_v2 #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_p_data,
    input  logic                     RX_d_valid,
    input  logic [DATA_WIDTH-1:0]    Rd_data,
    input  logic                     RdData_valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_VALID,
    input  logic                     FIFO_full,
    output logic                     ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     CLK_EN,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic                     WrEN,
    output logic                     RdEN,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic [DATA_WIDTH-1:0]    TX_p_data,
    output logic                     TX_d_valid,
    output logic                     clk_div_en,
    output logic                     frame_err,
    output logic                     busy
);
    localparam int NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int NSLOTS = 1 << IDXW;
    localparam int CW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDXW-1:0]       LAST_ALU = IDXW'(NBYTES - 1);
    localparam logic [CW-1:0]         TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN  = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_DATA, S_WR, S_RD_REQ, S_RD_WAIT,
        S_OPA, S_OPB, S_FUN, S_ALU_RUN, S_TX
    } state_t;

    state_t                   state, state_nxt;
    logic [DATA_WIDTH-1:0]    cmd, cmd_nxt;
    logic [ADDR_WIDTH-1:0]    addr, addr_nxt;
    logic [DATA_WIDTH-1:0]    wdata, wdata_nxt;
    logic [ALU_FUN_WIDTH-1:0] fun, fun_nxt;
    logic [ALU_OUT_WIDTH-1:0] txbuf, txbuf_nxt;
    logic [IDXW-1:0]          idx, idx_nxt;
    logic [IDXW-1:0]          last, last_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic                     wr_en_nxt, rd_en_nxt, tx_valid_nxt, err_nxt, abort;
    logic [ADDR_WIDTH-1:0]    address_nxt;
    logic [DATA_WIDTH-1:0]    wr_data_nxt, tx_data_nxt;
    logic                     waiting, timed_out;
    logic [DATA_WIDTH-1:0]    tx_bytes [NSLOTS];

    for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
        if (g < NBYTES) begin : g_used
            assign tx_bytes[g] = txbuf[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign tx_bytes[g] = '0;
        end
    end

    assign waiting   = (state == S_ADDR) || (state == S_DATA) || (state == S_OPA) ||
                       (state == S_OPB) || (state == S_FUN) || (state == S_RD_WAIT) ||
                       (state == S_ALU_RUN) || (state == S_TX);
    assign timed_out = (cnt == TO_LAST);

    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        fun_nxt      = fun;
        txbuf_nxt    = txbuf;
        idx_nxt      = idx;
        last_nxt     = last;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        tx_valid_nxt = 1'b0;
        err_nxt      = 1'b0;
        abort        = 1'b0;
        address_nxt  = Address;
        wr_data_nxt  = WrData;
        tx_data_nxt  = TX_p_data;
        case (state)
            S_IDLE: if (RX_d_valid) begin
                cmd_nxt = RX_p_data;
                if (RX_p_data == CMD_WR || RX_p_data == CMD_RD) state_nxt = S_ADDR;
                else if (RX_p_data == CMD_ALU)                  state_nxt = S_OPA;
                else if (RX_p_data == CMD_FUN)                  state_nxt = S_FUN;
                else                                            err_nxt   = 1'b1;
            end
            S_ADDR: if (RX_d_valid) begin
                addr_nxt  = RX_p_data[ADDR_WIDTH-1:0];
                state_nxt = (cmd == CMD_WR) ? S_DATA : S_RD_REQ;
            end else if (timed_out) abort = 1'b1;
            S_DATA: if (RX_d_valid) begin
                wdata_nxt = RX_p_data;
                state_nxt = S_WR;
            end else if (timed_out) abort = 1'b1;
            S_WR:     state_nxt = S_IDLE;
            S_RD_REQ: state_nxt = S_RD_WAIT;
            S_RD_WAIT: if (RdData_valid) begin
                txbuf_nxt = ALU_OUT_WIDTH'(Rd_data);
                last_nxt  = '0;
                idx_nxt   = '0;
                state_nxt = S_TX;
            end else if (timed_out) abort = 1'b1;
            S_OPA, S_OPB: if (RX_d_valid) begin
                // operands land in RF locations 0 and 1 for the ALU to pick up
                wr_en_nxt   = 1'b1;
                address_nxt = (state == S_OPA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
                wr_data_nxt = RX_p_data;
                state_nxt   = (state == S_OPA) ? S_OPB : S_FUN;
            end else if (timed_out) abort = 1'b1;
            S_FUN: if (RX_d_valid) begin
                fun_nxt   = RX_p_data[ALU_FUN_WIDTH-1:0];
                state_nxt = S_ALU_RUN;
            end else if (timed_out) abort = 1'b1;
            S_ALU_RUN: if (OUT_VALID) begin
                txbuf_nxt = ALU_OUT;
                last_nxt  = LAST_ALU;
                idx_nxt   = '0;
                state_nxt = S_TX;
            end else if (timed_out) abort = 1'b1;
            S_TX: if (!FIFO_full) begin
                tx_valid_nxt = 1'b1;
                tx_data_nxt  = tx_bytes[idx];
                if (idx == last) state_nxt = S_IDLE;
                else             idx_nxt   = idx + 1'b1;
            end else if (timed_out) abort = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
        end
        if (state_nxt == S_WR) begin
            wr_en_nxt   = 1'b1;
            address_nxt = addr_nxt;
            wr_data_nxt = wdata_nxt;
        end
        if (state_nxt == S_RD_REQ) begin
            rd_en_nxt   = 1'b1;
            address_nxt = addr_nxt;
        end
        if (!waiting || state_nxt != state || RX_d_valid) cnt_nxt = '0;
        else                                              cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cmd        <= '0;
            addr       <= '0;
            wdata      <= '0;
            fun        <= '0;
            txbuf      <= '0;
            idx        <= '0;
            last       <= '0;
            cnt        <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLK_EN     <= 1'b0;
            Address    <= '0;
            WrEN       <= 1'b0;
            RdEN       <= 1'b0;
            WrData     <= '0;
            TX_p_data  <= '0;
            TX_d_valid <= 1'b0;
            clk_div_en <= 1'b1;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd        <= cmd_nxt;
            addr       <= addr_nxt;
            wdata      <= wdata_nxt;
            fun        <= fun_nxt;
            txbuf      <= txbuf_nxt;
            idx        <= idx_nxt;
            last       <= last_nxt;
            cnt        <= cnt_nxt;
            ALU_EN     <= (state_nxt == S_ALU_RUN);
            ALU_FUN    <= fun_nxt;
            CLK_EN     <= (state_nxt == S_ALU_RUN);
            Address    <= address_nxt;
            WrEN       <= wr_en_nxt;
            RdEN       <= rd_en_nxt;
            WrData     <= wr_data_nxt;
            TX_p_data  <= tx_data_nxt;
            TX_d_valid <= tx_valid_nxt;
            clk_div_en <= 1'b1;
            frame_err  <= err_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end
endmodule

// File: tb/tb_sys_cntrl_v2.sv
// tb/tb_sys_cntrl_v2.sv - directed bench for sys_cntrl_v2 with short timeout
module tb_sys_cntrl_v2;
    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_p_data;
    logic        RX_d_valid;
    logic [7:0]  Rd_data;
    logic        RdData_valid;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        FIFO_full;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_EN;
    logic [3:0]  Address;
    logic        WrEN;
    logic        RdEN;
    logic [7:0]  WrData;
    logic [7:0]  TX_p_data;
    logic        TX_d_valid;
    logic        clk_div_en;
    logic        frame_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [7:0]  txq [$];
    logic [11:0] wrq [$];

    sys_cntrl_v2 #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST), .RX_p_data(RX_p_data), .RX_d_valid(RX_d_valid),
        .Rd_data(Rd_data), .RdData_valid(RdData_valid), .ALU_OUT(ALU_OUT),
        .OUT_VALID(OUT_VALID), .FIFO_full(FIFO_full), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .Address(Address), .WrEN(WrEN),
        .RdEN(RdEN), .WrData(WrData), .TX_p_data(TX_p_data), .TX_d_valid(TX_d_valid),
        .clk_div_en(clk_div_en), .frame_err(frame_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (TX_d_valid) txq.push_back(TX_p_data);
        if (WrEN)       wrq.push_back({Address, WrData});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_p_data  = b;
        RX_d_valid = 1'b1;
        step();
        RX_d_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        step();
        step();
    endtask

    initial begin
        RST = 1'b1; RX_p_data = '0; RX_d_valid = 1'b0; Rd_data = '0; RdData_valid = 1'b0;
        ALU_OUT = '0; OUT_VALID = 1'b0; FIFO_full = 1'b0;
        step(); step();
        check("rst_wren",   {31'd0, WrEN},       32'd0);
        check("rst_aluen",  {31'd0, ALU_EN},     32'd0);
        check("rst_txv",    {31'd0, TX_d_valid}, 32'd0);
        check("rst_busy",   {31'd0, busy},       32'd0);
        check("rst_clkdiv", {31'd0, clk_div_en}, 32'd1);
        RST = 1'b0;
        step();

        // RF write
        txq.delete(); wrq.delete();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check("wr_en",   {31'd0, WrEN}, 32'd1);
        check("wr_addr", {28'd0, Address}, 32'h5);
        check("wr_data", {24'd0, WrData}, 32'h3C);
        step();
        check("wr_en_drop", {31'd0, WrEN}, 32'd0);
        check("wr_busy",    {31'd0, busy}, 32'd0);
        step();
        check("wr_no_tx",   txq.size(), 32'd0);

        // RF read
        txq.delete();
        send_byte(8'hBB); send_byte(8'h05);
        check("rd_en",   {31'd0, RdEN}, 32'd1);
        check("rd_addr", {28'd0, Address}, 32'h5);
        step(); step();
        Rd_data = 8'h3C; RdData_valid = 1'b1;
        step();
        RdData_valid = 1'b0;
        wait_idle("rd_idle");
        check("rd_tx_n", txq.size(), 32'd1);
        if (txq.size() > 0) check("rd_tx_b", {24'd0, txq[0]}, 32'h3C);

        // ALU with operands
        txq.delete(); wrq.delete();
        send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
        check("alu_en",  {31'd0, ALU_EN}, 32'd1);
        check("alu_cen", {31'd0, CLK_EN}, 32'd1);
        check("alu_fun", {28'd0, ALU_FUN}, 32'd0);
        step();
        ALU_OUT = 16'h0030; OUT_VALID = 1'b1;
        step();
        OUT_VALID = 1'b0;
        check("alu_en_drop",  {31'd0, ALU_EN}, 32'd0);
        check("alu_cen_drop", {31'd0, CLK_EN}, 32'd0);
        wait_idle("alu_idle");
        check("op_wr_n", wrq.size(), 32'd2);
        if (wrq.size() >= 2) begin
            check("op_wr0", {20'd0, wrq[0]}, 32'h010);
            check("op_wr1", {20'd0, wrq[1]}, 32'h120);
        end
        check("alu_tx_n", txq.size(), 32'd2);
        if (txq.size() >= 2) begin
            check("alu_tx0", {24'd0, txq[0]}, 32'h30);
            check("alu_tx1", {24'd0, txq[1]}, 32'h00);
        end

        // ALU without operands, backpressure between bytes
        txq.delete();
        send_byte(8'hDD); send_byte(8'h02);
        check("fun_val", {28'd0, ALU_FUN}, 32'd2);
        ALU_OUT = 16'hABCD; OUT_VALID = 1'b1;
        step();
        OUT_VALID = 1'b0;
        step();
        check("bp_b0_v", {31'd0, TX_d_valid}, 32'd1);
        check("bp_b0_d", {24'd0, TX_p_data}, 32'hCD);
        FIFO_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", {31'd0, TX_d_valid}, 32'd0);
        end
        FIFO_full = 1'b0;
        step();
        check("bp_b1_v", {31'd0, TX_d_valid}, 32'd1);
        check("bp_b1_d", {24'd0, TX_p_data}, 32'hAB);
        wait_idle("bp_idle");
        check("bp_tx_n", txq.size(), 32'd2);

        // inter-byte timeout
        wrq.delete();
        send_byte(8'hAA); send_byte(8'h03);
        for (int i = 0; i < 7; i++) step();
        check("to_early",  {31'd0, frame_err}, 32'd0);
        check("to_busy",   {31'd0, busy}, 32'd1);
        step();
        check("to_err",    {31'd0, frame_err}, 32'd1);
        check("to_idle",   {31'd0, busy}, 32'd0);
        step();
        check("to_err_1c", {31'd0, frame_err}, 32'd0);
        check("to_no_wr",  wrq.size(), 32'd0);

        // unknown command
        send_byte(8'h77);
        check("bad_cmd_err",  {31'd0, frame_err}, 32'd1);
        check("bad_cmd_busy", {31'd0, busy}, 32'd0);
        step();
        check("bad_cmd_1c",   {31'd0, frame_err}, 32'd0);

        // reset during ALU_RUN, then a normal read
        send_byte(8'hDD); send_byte(8'h05);
        check("pre_rst_aluen", {31'd0, ALU_EN}, 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("mrst_aluen", {31'd0, ALU_EN}, 32'd0);
        check("mrst_cen",   {31'd0, CLK_EN}, 32'd0);
        check("mrst_busy",  {31'd0, busy}, 32'd0);
        check("mrst_err",   {31'd0, frame_err}, 32'd0);
        check("mrst_fun",   {28'd0, ALU_FUN}, 32'd0);
        txq.delete();
        send_byte(8'hBB); send_byte(8'h07);
        check("post_rd_en",   {31'd0, RdEN}, 32'd1);
        check("post_rd_addr", {28'd0, Address}, 32'h7);
        step();
        Rd_data = 8'h5A; RdData_valid = 1'b1;
        step();
        RdData_valid = 1'b0;
        wait_idle("post_idle");
        check("post_tx_n", txq.size(), 32'd1);
        if (txq.size() > 0) check("post_tx_b", {24'd0, txq[0]}, 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
